max31855_spi_master: RTL and testbench
======================================

Name: max31855_spi_master

Overview:
- Free-running, read-only SPI master for a MAX31855 thermocouple-to-digital converter.
- Periodically asserts chip select and clocks in one 32-bit frame, MSB first.
- Presents the last complete frame on a parallel 32-bit output.
- Sits between the board-level SPI pins and downstream temperature decode/UART logic.

Parameters:
- CLK_DIV, 10: system clocks per SCK half-period. 100 MHz clk_i gives 5 MHz SCK. Legal values are 1 and above.
- IDLE_CYCLES, 10_000_000: system clocks spent with CS high between frames (100 ms at 100 MHz, which covers the device conversion time). Legal values are 1 and above.

Ports:
- clk_i, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- SPI_clk, output, 1: SCK to the device; idles low.
- SPI_cs, output, 1: active-low chip select.
- SPI_Data_In, input, 1: MISO from the device.
- SPI_Data_Out, output, 32: last complete frame; bit 31 is the first bit received.
- data_valid, output, 1: one-cycle pulse when SPI_Data_Out is updated.

Behaviour:
- Reset state: SPI_cs=1, SPI_clk=0, SPI_Data_Out=0, data_valid=0, state=IDLE, all counters 0.
- Reset overrides every state. Asserting it mid-frame aborts the frame immediately and produces no data_valid.
- All outputs are registered. SPI_Data_In is sampled raw, with no synchronizer.
- IDLE:
  - SPI_cs=1, SPI_clk=0.
  - Count IDLE_CYCLES cycles, then go to SETUP.
  - This wait also applies to the first frame after reset: CS falls IDLE_CYCLES cycles after reset deasserts.
- SETUP:
  - SPI_cs=0, SPI_clk=0 for CLK_DIV cycles (CS-to-first-SCK setup time).
  - Bit counter cleared. Go to SHIFT.
- SHIFT, repeated for 32 bits:
  - SCK low phase: SPI_clk=0 for CLK_DIV cycles.
  - SCK high phase: SPI_clk=1 for CLK_DIV cycles.
  - Sampling: on the clk_i edge that drives SPI_clk 0->1, the shift register takes {shift[30:0], SPI_Data_In}.
  - After the high phase of bit 32, SPI_clk returns to 0 and the state goes to HOLD.
  - Exactly 32 SCK rising edges occur per frame. SCK period is 2*CLK_DIV cycles.
- HOLD:
  - SPI_cs stays 0 with SPI_clk=0 for CLK_DIV cycles.
  - On exit: SPI_cs=1, SPI_Data_Out<=shift register, data_valid=1 for exactly that one cycle, then go to IDLE.
- Frame timing:
  - CS low time is CLK_DIV*66 cycles.
  - Repetition period is IDLE_CYCLES + CLK_DIV*66 cycles.
- SPI_Data_Out holds its previous value for the whole frame. It changes only at the data_valid cycle.
- The block does no decoding of fault or temperature fields.

Test Plan:
- Slave model for all scenarios: drives D31 when CS falls, then the next bit after each SCK falling edge. Parameters are CLK_DIV=2, IDLE_CYCLES=8.
- Reset check: hold reset 5 cycles -> SPI_cs=1, SPI_clk=0, SPI_Data_Out=0x00000000, data_valid=0. After release, CS falls exactly 8 cycles later.
- Single frame with slave data 0x42212007:
  - Exactly 32 SCK rising edges, each with period 4 cycles.
  - CS low for 132 cycles.
  - SPI_Data_Out=0x42212007 together with a single data_valid pulse coincident with CS rising.
- Alternating frames 0xFFFFFFFF, 0x00000000, 0xA5A5A5A5:
  - Each value appears in turn.
  - Output is stable between pulses.
  - CS rising edges are 140 cycles apart.
- Output hold: during the second frame's SHIFT, SPI_Data_Out still reads the first frame's value.
- Reset asserted after the 10th SCK rising edge:
  - Next cycle gives SPI_cs=1, SPI_clk=0, SPI_Data_Out=0, no data_valid.
  - A fresh full frame follows and is received correctly.

Source files
------------

// File: rtl/max31855_spi_master.sv
// Free-running read-only SPI master for the MAX31855: waits with CS high, then
// clocks in one 32-bit frame MSB first and publishes it with a one-cycle strobe.
module max31855_spi_master #(
  parameter int CLK_DIV     = 10,
  parameter int IDLE_CYCLES = 10_000_000
) (
  input  logic        clk_i,
  input  logic        reset,
  output logic        SPI_clk,
  output logic        SPI_cs,
  input  logic        SPI_Data_In,
  output logic [31:0] SPI_Data_Out,
  output logic        data_valid
);

  localparam int MAXC = (IDLE_CYCLES > CLK_DIV) ? IDLE_CYCLES : CLK_DIV;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic          hi_q, hi_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    hi_d    = hi_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (cnt_q == IDLE_LAST) begin
          state_d = SETUP;
          cnt_d   = '0;
          cs_d    = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!hi_q) begin
            // Sample on the same edge that raises SCK; the slave's bit has
            // been stable since the previous falling edge.
            hi_d    = 1'b1;
            sclk_d  = 1'b1;
            shift_d = {shift_q[30:0], SPI_Data_In};
          end else begin
            hi_d   = 1'b0;
            sclk_d = 1'b0;
            if (bit_q == 5'd31) state_d = HOLD;
            else                bit_d   = bit_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          cs_d    = 1'b1;
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign SPI_clk      = sclk_q;
  assign SPI_cs       = cs_q;
  assign SPI_Data_Out = data_q;
  assign data_valid   = valid_q;

endmodule

// File: tb/tb_max31855_spi_master.sv
// Bench for max31855_spi_master: behavioural MAX31855 slave plus frame-level
// timing/data model (expected word, CS low time, SCK count/period, frame period).
module tb_max31855_spi_master;
  localparam int DIV  = 2;
  localparam int IDLE = 8;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic        SPI_Data_In = 1'b0;
  logic        SPI_clk, SPI_cs, data_valid;
  logic [31:0] SPI_Data_Out;

  max31855_spi_master #(.CLK_DIV(DIV), .IDLE_CYCLES(IDLE)) dut (
    .clk_i(clk_i), .reset(reset), .SPI_clk(SPI_clk), .SPI_cs(SPI_cs),
    .SPI_Data_In(SPI_Data_In), .SPI_Data_Out(SPI_Data_Out), .data_valid(data_valid)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int errors = 0, checks = 0;
  logic [31:0] slave_word = '0;
  logic [31:0] exp_out = '0;
  int sidx = 0;
  int last_rise = -1;

  // Slave: D31 on CS fall, next bit after each SCK falling edge.
  always @(negedge SPI_cs) begin
    sidx = 31;
    SPI_Data_In = slave_word[31];
  end
  always @(negedge SPI_clk) begin
    if (SPI_cs === 1'b0 && sidx > 0) begin
      sidx--;
      SPI_Data_In = slave_word[sidx];
    end
  end

  task automatic run_frame(input logic [31:0] w, input string nm, input bit chk_rep);
    int n, low, rises, prev_rise, badper, badout, pulses;
    logic psclk;
    slave_word = w;
    n = 0;
    while (SPI_cs !== 1'b0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s cs_fall_timeout: waited %0d cycles, required < 200", nm, n);
      return;
    end
    low = 0; rises = 0; prev_rise = -1; badper = 0; badout = 0; pulses = 0; psclk = 1'b0;
    while (SPI_cs === 1'b0 && low < 400) begin
      low++;
      if (SPI_clk === 1'b1 && psclk === 1'b0) begin
        rises++;
        if (prev_rise >= 0 && cyc - prev_rise != 2*DIV) badper++;
        prev_rise = cyc;
      end
      psclk = SPI_clk;
      if (data_valid !== 1'b0) pulses++;
      if (SPI_Data_Out !== exp_out) badout++;
      @(negedge clk_i);
    end
    exp_out = w;
    checks++;
    if (low != 66*DIV) begin errors++; $display("FAIL %s cs_low: got %0d required %0d", nm, low, 66*DIV); end
    checks++;
    if (rises != 32) begin errors++; $display("FAIL %s sck_rises: got %0d required 32", nm, rises); end
    checks++;
    if (badper != 0) begin errors++; $display("FAIL %s sck_period: %0d periods not equal to %0d", nm, badper, 2*DIV); end
    checks++;
    if (badout != 0) begin errors++; $display("FAIL %s output_hold: %0d cycles changed during frame", nm, badout); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL %s early_valid: got %0d pulses while CS low, required 0", nm, pulses); end
    checks++;
    if (data_valid !== 1'b1) begin errors++; $display("FAIL %s valid_at_cs_rise: got %b required 1", nm, data_valid); end
    checks++;
    if (SPI_Data_Out !== w) begin errors++; $display("FAIL %s data: got %h required %h", nm, SPI_Data_Out, w); end
    if (chk_rep && last_rise >= 0) begin
      checks++;
      if (cyc - last_rise != IDLE + 66*DIV) begin
        errors++;
        $display("FAIL %s frame_period: got %0d required %0d", nm, cyc - last_rise, IDLE + 66*DIV);
      end
    end
    last_rise = cyc;
    @(negedge clk_i);
    checks++;
    if (data_valid !== 1'b0 || SPI_Data_Out !== w) begin
      errors++;
      $display("FAIL %s after_pulse: valid=%b data=%h required valid=0 data=%h", nm, data_valid, SPI_Data_Out, w);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (5) @(negedge clk_i);
    checks++;
    if (SPI_cs !== 1'b1 || SPI_clk !== 1'b0 || SPI_Data_Out !== 32'h0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cs=%b clk=%b out=%h valid=%b required 1 0 00000000 0",
               SPI_cs, SPI_clk, SPI_Data_Out, data_valid);
    end
    // Load the first frame's word before CS can fall.
    slave_word = 32'h42212007;
    exp_out = '0;
    last_rise = -1;
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (SPI_cs !== 1'b0 && n < 50);
    checks++;
    if (n != IDLE) begin errors++; $display("FAIL first_cs_delay: got %0d required %0d", n, IDLE); end
  endtask

  task automatic test_single_frame();
    run_frame(32'h42212007, "single", 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(32'hFFFFFFFF, "alt_ff", 1'b1);
    run_frame(32'h00000000, "alt_00", 1'b1);
    run_frame(32'hA5A5A5A5, "alt_a5", 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_frame($urandom, "random", 1'b1);
  endtask

  task automatic test_mid_reset();
    int n, rises;
    logic psclk;
    slave_word = $urandom;
    n = 0;
    while (SPI_cs !== 1'b0 && n < 200) begin @(negedge clk_i); n++; end
    rises = 0; psclk = 1'b0;
    while (rises < 10 && n < 400) begin
      if (SPI_clk === 1'b1 && psclk === 1'b0) rises++;
      psclk = SPI_clk;
      if (rises < 10) begin @(negedge clk_i); n++; end
    end
    checks++;
    if (rises != 10) begin errors++; $display("FAIL mid_reset_setup: got %0d rises required 10", rises); end
    reset = 1'b1;
    @(negedge clk_i);
    checks++;
    if (SPI_cs !== 1'b1 || SPI_clk !== 1'b0 || SPI_Data_Out !== 32'h0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: cs=%b clk=%b out=%h valid=%b required 1 0 00000000 0",
               SPI_cs, SPI_clk, SPI_Data_Out, data_valid);
    end
    reset = 1'b0;
    exp_out = '0;
    last_rise = -1;
    run_frame($urandom, "after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
